// File: rtl/pool_collect.sv
// Frames an upstream sample stream into pooling windows for the max-pool stage,
// captures each window maximum after the pool latency and packs them into a FWFT output FIFO.
module pool_collect #(
    parameter int NUM_WIDTH    = 16,
    parameter int NUM_PER_WORD = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int POOL_LATENCY = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CNT_WIDTH-1:0]              cfg_window,
    input  logic                              flush,
    input  logic                              up_valid,
    output logic                              up_ready,
    output logic                              pool_restart,
    input  logic [NUM_WIDTH-1:0]              pool_data,
    output logic [NUM_WIDTH*NUM_PER_WORD-1:0] dn_data,
    output logic                              dn_valid,
    input  logic                              dn_ready
);
    // Handshakes: a sample moves on up_valid & up_ready; a word moves on dn_valid & dn_ready.
    // The pool stage never stalls, so the producer must gate up_valid with up_ready.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = (NUM_PER_WORD > 1) ? $clog2(NUM_PER_WORD) : 1;
    localparam int WW = NUM_WIDTH * NUM_PER_WORD;

    logic [CNT_WIDTH-1:0]                    r_win_cnt;
    logic [CNT_WIDTH-1:0]                    r_win_size;
    logic [POOL_LATENCY-1:0]                 r_tok;
    logic [LW-1:0]                           r_lane;
    logic [NUM_PER_WORD-1:0][NUM_WIDTH-1:0]  r_asm;
    logic                                    r_flush_pend;
    logic [WW-1:0]                           r_mem [FIFO_DEPTH];
    logic [AW-1:0]                           r_wr;
    logic [AW-1:0]                           r_rd;
    logic [AW:0]                             r_count;

    logic [CNT_WIDTH-1:0]                    w_cfg_eff;
    logic [CNT_WIDTH-1:0]                    w_size;
    logic                                    w_accept;
    logic                                    w_win_end;
    logic                                    w_capture;
    logic                                    w_word_done;
    logic                                    w_flush_clr;
    logic                                    w_flush_act;
    logic                                    w_push;
    logic                                    w_pop;
    logic [NUM_PER_WORD-1:0][NUM_WIDTH-1:0]  w_push_word;
    logic [7:0]                              w_inflight;
    logic [7:0]                              w_lane_sum;
    logic [7:0]                              w_commit;
    logic [7:0]                              w_free;

    // The first sample of a window already uses the freshly latched window size.
    assign w_cfg_eff   = (cfg_window == '0) ? CNT_WIDTH'(1) : cfg_window;
    assign w_size      = (r_win_cnt == '0) ? w_cfg_eff : r_win_size;
    assign w_accept    = up_valid & up_ready;
    assign w_win_end   = w_accept & (r_win_cnt == w_size - CNT_WIDTH'(1));
    assign pool_restart = w_accept & (r_win_cnt == '0);

    assign w_capture   = r_tok[POOL_LATENCY-1];
    assign w_word_done = w_capture & (r_lane == LW'(NUM_PER_WORD - 1));
    assign w_flush_clr = r_flush_pend & ~(|r_tok);
    assign w_flush_act = w_flush_clr & (r_lane != '0);
    assign w_push      = w_word_done | w_flush_act;
    assign w_pop       = (r_count != '0) & dn_ready;

    always_comb begin
        w_push_word = r_asm;
        if (w_capture) w_push_word[r_lane] = pool_data;
    end

    always_comb begin
        w_inflight = 8'd0;
        for (int i = 0; i < POOL_LATENCY; i++) w_inflight = w_inflight + 8'(r_tok[i]);
    end

    // Words already promised by in-flight window ends or a pending partial flush
    // are reserved so a push can never land on a full FIFO.
    assign w_lane_sum = 8'(r_lane) + w_inflight;
    assign w_commit   = (w_lane_sum / 8'(NUM_PER_WORD)) +
                        ((r_flush_pend && ((w_lane_sum % 8'(NUM_PER_WORD)) != 8'd0)) ? 8'd1 : 8'd0);
    assign w_free     = 8'(FIFO_DEPTH) - 8'(r_count) + 8'(w_pop);
    assign up_ready   = ~rst & (w_free >= w_commit + 8'd2);

    assign dn_valid = (r_count != '0);
    assign dn_data  = dn_valid ? r_mem[r_rd] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt    <= '0;
            r_win_size   <= CNT_WIDTH'(1);
            r_tok        <= '0;
            r_lane       <= '0;
            r_asm        <= '0;
            r_flush_pend <= 1'b0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_count      <= '0;
        end else begin
            if (r_win_cnt == '0) r_win_size <= w_cfg_eff;
            if (w_accept) r_win_cnt <= w_win_end ? '0 : r_win_cnt + CNT_WIDTH'(1);

            r_tok[0] <= w_win_end;
            for (int i = 1; i < POOL_LATENCY; i++) r_tok[i] <= r_tok[i-1];

            if (w_word_done || w_flush_act) begin
                r_asm  <= '0;
                r_lane <= '0;
            end else if (w_capture) begin
                r_asm[r_lane] <= pool_data;
                r_lane        <= r_lane + LW'(1);
            end

            // A flush arriving as an older one retires stays pending for the next round.
            r_flush_pend <= flush | (r_flush_pend & ~w_flush_clr);

            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_push_word;
    end

endmodule

// File: tb/tb_pool_collect.sv
// Bench for pool_collect: a behavioural max-pool stage, a window/lane reference model
// feeding an expected-word queue, and a scoreboard on the output handshake.
module tb_pool_collect;
  localparam int NW = 16;
  localparam int NPW = 4;
  localparam int CW = 8;
  localparam int LAT = 4;
  localparam int DEPTH = 4;

  logic clk, rst, flush, up_ready, pool_restart, dn_valid, dn_ready, up_valid;
  logic [CW-1:0] cfg_window;
  logic [NW-1:0] pool_data;
  logic [NW*NPW-1:0] dn_data;

  logic r_want;
  logic signed [NW-1:0] r_x;
  logic signed [NW-1:0] p_m, p_d1, p_d2, p_d3;
  int rdy_mode;
  bit saw_throttle;

  int total = 0;
  int bad = 0;

  int m_k, m_idx;
  logic signed [NW-1:0] m_max;
  logic [NW-1:0] m_lanes[$];
  logic [NW*NPW-1:0] exp_q[$];

  pool_collect #(.NUM_WIDTH(NW), .NUM_PER_WORD(NPW), .CNT_WIDTH(CW),
                 .POOL_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_window(cfg_window), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .pool_restart(pool_restart),
    .pool_data(pool_data), .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // producer gates its valid with up_ready
  assign up_valid = r_want & up_ready;

  // behavioural max-pool stage: running max, result visible LAT cycles after the last sample
  always @(posedge clk) begin
    if (up_valid) p_m <= pool_restart ? r_x : ((r_x > p_m) ? r_x : p_m);
    p_d1 <= p_m;
    p_d2 <= p_d1;
    p_d3 <= p_d2;
  end
  assign pool_data = p_d3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  task automatic model_push_lane(input logic [NW-1:0] v);
    m_lanes.push_back(v);
    if (m_lanes.size() == NPW) begin
      exp_q.push_back({m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]});
      m_lanes.delete();
    end
  endtask

  task automatic model_flush();
    if (m_lanes.size() > 0) begin
      while (m_lanes.size() < NPW) m_lanes.push_back('0);
      exp_q.push_back({m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]});
      m_lanes.delete();
    end
  endtask

  task automatic set_cfg(input int c);
    @(negedge clk);
    cfg_window = CW'(c);
    m_k = (c == 0) ? 1 : c;
  endtask

  // driver tasks
  task automatic send_sample(input logic signed [NW-1:0] x);
    int waited;
    bit acc;
    waited = 0;
    acc = 1'b0;
    @(negedge clk);
    r_x = x;
    r_want = 1'b1;
    while (!acc && waited < 300) begin
      #1;
      acc = up_ready;
      if (!acc) begin
        @(negedge clk);
        waited++;
      end
    end
    if (!acc) begin
      chk("accept_timeout", 64'd0, 64'd1);
      r_want = 1'b0;
      return;
    end
    chk("restart", 64'(pool_restart), 64'(m_idx == 0));
    if (m_idx == 0 || x > m_max) m_max = x;
    m_idx++;
    if (m_idx == m_k) begin
      model_push_lane(m_max);
      m_idx = 0;
    end
    @(posedge clk);
    #1;
    r_want = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    repeat (LAT + 4) @(negedge clk);
    while ((exp_q.size() > 0 || dn_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // consumer ready pattern
  always @(negedge clk) begin
    case (rdy_mode)
      0: dn_ready = 1'b1;
      1: dn_ready = 1'b0;
      default: dn_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard and protocol monitors
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (dn_valid && dn_ready) begin
        if (exp_q.size() == 0) chk("spurious_word_qsize", 64'(exp_q.size()), 64'd1);
        else chk("word", dn_data, exp_q.pop_front());
      end
      if (dut.w_push && !dut.w_pop && dut.r_count == DEPTH) chk("push_while_full", 64'd1, 64'd0);
      if (pool_restart && !up_valid) chk("restart_without_valid", 64'(pool_restart), 64'd0);
      if (rdy_mode == 1 && !up_ready) saw_throttle = 1'b1;
    end
  end

  initial begin
    logic signed [NW-1:0] t1 [16];
    t1 = '{16'sd1, 16'sd5, -16'sd10, 16'sd2,
           -16'sd3, -16'sd7, -16'sd100, -16'sd4,
           16'sd7, 16'sd0, 16'sd7, -16'sd1,
           16'sh7FFF, 16'sd0, -16'sd32768, 16'sd3};
    rst = 1'b1; flush = 1'b0; r_want = 1'b0; r_x = '0; cfg_window = 8'd4;
    rdy_mode = 0; saw_throttle = 1'b0; m_k = 4; m_idx = 0; m_max = '0;
    p_m = '0; p_d1 = '0; p_d2 = '0; p_d3 = '0;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_up_ready", 64'(up_ready), 64'd0);
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_dn_data", dn_data, 64'd0);
    chk("rst_restart", 64'(pool_restart), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("up_ready_after_rst", 64'(up_ready), 64'd1);

    // 1: window of 4, signed maxima, output timing
    set_cfg(4);
    for (int i = 0; i < 16; i++) send_sample(t1[i]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_valid_early", 64'(dn_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid_on_time", 64'(dn_valid), 64'd1);
    chk("t1_word_const", dn_data, 64'h7FFF_0007_FFFD_0005);
    wait_drain();

    // 2: window of 1 plus a partial flush
    set_cfg(1);
    for (int v = 1; v <= 6; v++) send_sample(16'(v));
    pulse_flush();
    model_flush();
    chk("t2_model_words", 64'(exp_q.size()), 64'd2);
    wait_drain();

    // 3: consumer stalled, producer throttled, then drained
    set_cfg(2);
    rdy_mode = 1;
    saw_throttle = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send_sample(16'($urandom_range(0, 16'hFFFF)));
      end
      begin
        repeat (60) @(negedge clk);
        rdy_mode = 0;
      end
    join
    chk("t3_throttle_seen", 64'(saw_throttle), 64'd1);
    wait_drain();

    // 4: window of 9 with producer gaps and random consumer readiness
    set_cfg(9);
    rdy_mode = 2;
    for (int i = 0; i < 36; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_sample(16'($urandom_range(0, 16'hFFFF)));
    end
    wait_drain();
    rdy_mode = 0;

    // 5: reset while a window result is in flight
    set_cfg(2);
    send_sample(16'sd11);
    send_sample(16'sd22);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_lanes.delete();
    m_idx = 0;
    repeat (LAT + 2) @(negedge clk);
    chk("t5_no_word", 64'(dn_valid), 64'd0);
    for (int i = 0; i < 8; i++) send_sample(16'(i * 3 + 1));
    wait_drain();

    // 6a: flush with empty assembly
    pulse_flush();
    model_flush();
    repeat (10) @(negedge clk);
    chk("t6_empty_flush", 64'(dn_valid), 64'd0);

    // 6b: flush coincident with the completing capture, window size 0 as 1
    set_cfg(0);
    for (int i = 0; i < 4; i++) send_sample(-16'(i + 2));
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
    chk("t6_model_words", 64'(exp_q.size()), 64'd1);
    wait_drain();
    repeat (10) @(negedge clk);
    chk("t6_no_pad_word", 64'(dn_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
